// File: rtl/arm_pkg.sv
// Shared ARM core definitions: ALU command encodings, datapath widths and the
// control bundle carried from ID into EXE.
package arm_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned SHIFT_OP_W = 12;
    localparam int unsigned IMM24_W    = 24;

    localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

    // EXE_CMD encodings; LDR/STR reuse ADD for address generation.
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic                  valid;
        logic [WORD_W-1:0]     pc;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  b;
        logic                  s;
        logic                  imm;
        logic [3:0]            exe_cmd;
        logic [REG_ADDR_W-1:0] dest;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic [IMM24_W-1:0]    signed_imm_24;
        logic [3:0]            status;
    } id_exe_ctrl_t;

endpackage

// File: rtl/operand_snoop.sv
// One held register operand with its source register and used flag; while held
// it tracks write-backs to its source so the value never goes stale.
module operand_snoop
    import arm_pkg::*;
#(
    parameter bit SNOOP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [WORD_W-1:0]     new_val,
    input  logic [REG_ADDR_W-1:0] new_src,
    input  logic                  new_used,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [WORD_W-1:0]     wb_data,
    output logic [WORD_W-1:0]     val,
    output logic [REG_ADDR_W-1:0] src,
    output logic                  used
);

    logic hit;

    // R15 lives outside the register file, so a write-back to it is never a match.
    assign hit = SNOOP && wb_en && (wb_dest != PC_REG) && used && (src == wb_dest);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            val  <= '0;
            src  <= '0;
            used <= 1'b0;
        end else if (capture) begin
            val  <= new_val;
            src  <= new_src;
            used <= new_used;
        end else if (hit) begin
            val <= wb_data;
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush, write-back snooping of held
// operands, and saturating stall/bubble counters.
module id_exe_reg
    import arm_pkg::*;
#(
    parameter bit          WB_SNOOP = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [WORD_W-1:0]     pc_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic                  imm_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic                  rn_used_in,
    input  logic                  rm_used_in,
    input  logic [WORD_W-1:0]     val_rn_in,
    input  logic [WORD_W-1:0]     val_rm_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [IMM24_W-1:0]    signed_imm_24_in,
    input  logic [3:0]            status_in,
    input  logic                  writeBackEn,
    input  logic [REG_ADDR_W-1:0] Dest_wb,
    input  logic [WORD_W-1:0]     Result_WB,
    output logic [WORD_W-1:0]     pc,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic                  b,
    output logic                  s,
    output logic                  imm,
    output logic [3:0]            exe_cmd,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [WORD_W-1:0]     val_rn,
    output logic [WORD_W-1:0]     val_rm,
    output logic [SHIFT_OP_W-1:0] shift_operand,
    output logic [IMM24_W-1:0]    signed_imm_24,
    output logic [3:0]            status,
    output logic                  exe_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    id_exe_ctrl_t ctrl_d, ctrl_q;
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;
    logic rn_used, rm_used;
    logic capture;

    assign capture = ~freeze;

    // A non-valid instruction enters as a bubble: side-effecting control bits
    // are masked, data fields still load.
    always_comb begin
        ctrl_d               = '0;
        ctrl_d.valid         = id_valid;
        ctrl_d.pc            = pc_in;
        ctrl_d.wb_en         = wb_en_in & id_valid;
        ctrl_d.mem_r_en      = mem_r_en_in & id_valid;
        ctrl_d.mem_w_en      = mem_w_en_in & id_valid;
        ctrl_d.b             = b_in & id_valid;
        ctrl_d.s             = s_in & id_valid;
        ctrl_d.imm           = imm_in;
        ctrl_d.exe_cmd       = exe_cmd_in;
        ctrl_d.dest          = dest_in;
        ctrl_d.shift_operand = shift_operand_in;
        ctrl_d.signed_imm_24 = signed_imm_24_in;
        ctrl_d.status        = status_in;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrl_q <= '0;
        end else if (capture) begin
            ctrl_q <= ctrl_d;
        end
    end

    // Flush wins over freeze, so a flushed cycle never counts as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (flush) begin
            if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CntOne;
        end else if (freeze) begin
            if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CntOne;
        end
    end

    operand_snoop #(
        .SNOOP (WB_SNOOP)
    ) u_rn (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .capture  (capture),
        .new_val  (val_rn_in),
        .new_src  (src1_in),
        .new_used (rn_used_in),
        .wb_en    (writeBackEn),
        .wb_dest  (Dest_wb),
        .wb_data  (Result_WB),
        .val      (val_rn),
        .src      (src1),
        .used     (rn_used)
    );

    operand_snoop #(
        .SNOOP (WB_SNOOP)
    ) u_rm (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .capture  (capture),
        .new_val  (val_rm_in),
        .new_src  (src2_in),
        .new_used (rm_used_in),
        .wb_en    (writeBackEn),
        .wb_dest  (Dest_wb),
        .wb_data  (Result_WB),
        .val      (val_rm),
        .src      (src2),
        .used     (rm_used)
    );

    assign exe_valid     = ctrl_q.valid;
    assign pc            = ctrl_q.pc;
    assign wb_en         = ctrl_q.wb_en;
    assign mem_r_en      = ctrl_q.mem_r_en;
    assign mem_w_en      = ctrl_q.mem_w_en;
    assign b             = ctrl_q.b;
    assign s             = ctrl_q.s;
    assign imm           = ctrl_q.imm;
    assign exe_cmd       = ctrl_q.exe_cmd;
    assign dest          = ctrl_q.dest;
    assign shift_operand = ctrl_q.shift_operand;
    assign signed_imm_24 = ctrl_q.signed_imm_24;
    assign status        = ctrl_q.status;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: a behavioural model pushes the expected register
// contents each cycle and the post-edge outputs are popped and compared.
module tb_id_exe_reg;
    import arm_pkg::*;

    localparam int unsigned CW = 4;

    typedef struct {
        logic [31:0]   pc;
        logic          wb_en, mem_r_en, mem_w_en, b, s, imm;
        logic [3:0]    exe_cmd, src1, src2, dest;
        logic [31:0]   val_rn, val_rm;
        logic [11:0]   shift_operand;
        logic [23:0]   signed_imm_24;
        logic [3:0]    status;
        logic          exe_valid;
        logic [CW-1:0] stall_cnt, bubble_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, freeze, flush, id_valid;
    logic [31:0] pc_in, val_rn_in, val_rm_in, Result_WB;
    logic wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0] exe_cmd_in, src1_in, src2_in, dest_in, status_in, Dest_wb;
    logic rn_used_in, rm_used_in, writeBackEn;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;

    logic [31:0] pc, val_rn, val_rm;
    logic wb_en, mem_r_en, mem_w_en, b, s, imm, exe_valid;
    logic [3:0] exe_cmd, src1, src2, dest, status;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    exp_t m;
    logic m_rn_used, m_rm_used;
    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    id_exe_reg #(
        .WB_SNOOP (1'b1),
        .CNT_W    (CW)
    ) dut (
        .clk (clk), .rst (rst), .freeze (freeze), .flush (flush), .id_valid (id_valid),
        .pc_in (pc_in), .wb_en_in (wb_en_in), .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in), .b_in (b_in), .s_in (s_in), .imm_in (imm_in),
        .exe_cmd_in (exe_cmd_in), .src1_in (src1_in), .src2_in (src2_in),
        .dest_in (dest_in), .rn_used_in (rn_used_in), .rm_used_in (rm_used_in),
        .val_rn_in (val_rn_in), .val_rm_in (val_rm_in),
        .shift_operand_in (shift_operand_in), .signed_imm_24_in (signed_imm_24_in),
        .status_in (status_in), .writeBackEn (writeBackEn), .Dest_wb (Dest_wb),
        .Result_WB (Result_WB), .pc (pc), .wb_en (wb_en), .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en), .b (b), .s (s), .imm (imm), .exe_cmd (exe_cmd),
        .src1 (src1), .src2 (src2), .dest (dest), .val_rn (val_rn), .val_rm (val_rm),
        .shift_operand (shift_operand), .signed_imm_24 (signed_imm_24),
        .status (status), .exe_valid (exe_valid), .stall_cnt (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    endtask

    task automatic rand_id();
        pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
        {exe_cmd_in, src1_in, src2_in, dest_in, status_in} = 20'($urandom);
        {rn_used_in, rm_used_in} = 2'($urandom);
        shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
        id_valid = 1'($urandom);
    endtask

    task automatic model_step();
        if (rst) begin
            m = '{default: '0};
            m_rn_used = 1'b0; m_rm_used = 1'b0;
        end else if (flush) begin
            logic [CW-1:0] sc, bc;
            sc = m.stall_cnt; bc = m.bubble_cnt;
            m = '{default: '0};
            m.stall_cnt = sc;
            m.bubble_cnt = (bc == '1) ? bc : bc + 1'b1;
            m_rn_used = 1'b0; m_rm_used = 1'b0;
        end else if (freeze) begin
            if (m.stall_cnt != '1) m.stall_cnt = m.stall_cnt + 1'b1;
            if (writeBackEn && Dest_wb != 4'd15) begin
                if (m_rn_used && m.src1 == Dest_wb) m.val_rn = Result_WB;
                if (m_rm_used && m.src2 == Dest_wb) m.val_rm = Result_WB;
            end
        end else begin
            m.pc = pc_in; m.imm = imm_in; m.exe_cmd = exe_cmd_in;
            m.wb_en = wb_en_in & id_valid; m.mem_r_en = mem_r_en_in & id_valid;
            m.mem_w_en = mem_w_en_in & id_valid; m.b = b_in & id_valid;
            m.s = s_in & id_valid; m.exe_valid = id_valid;
            m.src1 = src1_in; m.src2 = src2_in; m.dest = dest_in;
            m.val_rn = val_rn_in; m.val_rm = val_rm_in;
            m.shift_operand = shift_operand_in; m.signed_imm_24 = signed_imm_24_in;
            m.status = status_in;
            m_rn_used = rn_used_in; m_rm_used = rm_used_in;
        end
    endtask

    // Inputs are set >1 time unit before the edge; outputs are sampled 1 unit after.
    task automatic tick(input string tag);
        exp_t e;
        model_step();
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, "pc", pc, e.pc);
            chk(tag, "wb_en", 32'(wb_en), 32'(e.wb_en));
            chk(tag, "mem_r_en", 32'(mem_r_en), 32'(e.mem_r_en));
            chk(tag, "mem_w_en", 32'(mem_w_en), 32'(e.mem_w_en));
            chk(tag, "b", 32'(b), 32'(e.b));
            chk(tag, "s", 32'(s), 32'(e.s));
            chk(tag, "imm", 32'(imm), 32'(e.imm));
            chk(tag, "exe_cmd", 32'(exe_cmd), 32'(e.exe_cmd));
            chk(tag, "src1", 32'(src1), 32'(e.src1));
            chk(tag, "src2", 32'(src2), 32'(e.src2));
            chk(tag, "dest", 32'(dest), 32'(e.dest));
            chk(tag, "val_rn", val_rn, e.val_rn);
            chk(tag, "val_rm", val_rm, e.val_rm);
            chk(tag, "shift_operand", 32'(shift_operand), 32'(e.shift_operand));
            chk(tag, "signed_imm_24", 32'(signed_imm_24), 32'(e.signed_imm_24));
            chk(tag, "status", 32'(status), 32'(e.status));
            chk(tag, "exe_valid", 32'(exe_valid), 32'(e.exe_valid));
            chk(tag, "stall_cnt", 32'(stall_cnt), 32'(e.stall_cnt));
            chk(tag, "bubble_cnt", 32'(bubble_cnt), 32'(e.bubble_cnt));
        end
    endtask

    initial begin
        m = '{default: '0};
        m_rn_used = 1'b0; m_rm_used = 1'b0;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        writeBackEn = 1'b1; Dest_wb = 4'd3; Result_WB = 32'hDEAD_BEEF;
        rand_id();
        tick("reset0");
        rand_id(); freeze = 1'b1; flush = 1'b1;
        tick("reset1");

        // Plain capture
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; writeBackEn = 1'b0;
        rand_id();
        id_valid = 1'b1; pc_in = 32'h10; exe_cmd_in = EXE_ADD;
        val_rn_in = 32'd5; val_rm_in = 32'd7; dest_in = 4'd3;
        tick("capture");

        // Load operands to be held: Rn=R2 (0x11), Rm=R4 (0x44)
        rand_id();
        id_valid = 1'b1; wb_en_in = 1'b1; src1_in = 4'd2; src2_in = 4'd4;
        rn_used_in = 1'b1; rm_used_in = 1'b1; val_rn_in = 32'h11; val_rm_in = 32'h44;
        tick("load_hold");

        rand_id(); freeze = 1'b1;
        writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'hAB;
        tick("snoop_rn");
        rand_id(); Dest_wb = 4'd15; Result_WB = 32'hCD;
        tick("snoop_r15");
        rand_id(); writeBackEn = 1'b0; Dest_wb = 4'd4; Result_WB = 32'hEE;
        tick("snoop_wben0");

        // rn_used=0 must not snoop
        freeze = 1'b0; writeBackEn = 1'b0; rand_id();
        id_valid = 1'b1; src1_in = 4'd5; src2_in = 4'd9;
        rn_used_in = 1'b0; rm_used_in = 1'b1; val_rn_in = 32'h22; val_rm_in = 32'h99;
        tick("load_unused");
        rand_id(); freeze = 1'b1; writeBackEn = 1'b1; Dest_wb = 4'd5; Result_WB = 32'h55;
        tick("snoop_unused");

        // src1==src2: both operands refresh together
        freeze = 1'b0; writeBackEn = 1'b0; rand_id();
        id_valid = 1'b1; src1_in = 4'd6; src2_in = 4'd6;
        rn_used_in = 1'b1; rm_used_in = 1'b1; val_rn_in = 32'h66; val_rm_in = 32'h66;
        tick("load_same");
        rand_id(); freeze = 1'b1; writeBackEn = 1'b1; Dest_wb = 4'd6; Result_WB = 32'h1234;
        tick("snoop_both");

        // Flush over freeze
        rand_id(); flush = 1'b1; freeze = 1'b1;
        tick("flush_freeze");
        flush = 1'b0; freeze = 1'b0; writeBackEn = 1'b0;

        // Invalid instruction captured as bubble
        rand_id(); id_valid = 1'b0;
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; b_in = 1'b1; s_in = 1'b1;
        tick("bubble_in");

        // Stall counter saturation
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_id();
            writeBackEn = 1'b1; Dest_wb = 4'($urandom); Result_WB = $urandom;
            tick("stall_sat");
        end
        freeze = 1'b0; writeBackEn = 1'b0;

        // Bubble counter saturation
        for (int i = 0; i < 17; i++) begin
            rand_id(); flush = 1'b1; freeze = 1'($urandom);
            tick("bubble_sat");
        end
        flush = 1'b0; freeze = 1'b0;

        // Reset mid-stall, then normal capture
        rand_id(); id_valid = 1'b1; src1_in = 4'd7; rn_used_in = 1'b1;
        tick("pre_stall");
        freeze = 1'b1; writeBackEn = 1'b1; Dest_wb = 4'd7;
        for (int i = 0; i < 3; i++) begin
            rand_id(); Result_WB = $urandom;
            tick("mid_stall");
        end
        rand_id(); rst = 1'b1;
        tick("rst_mid_stall");
        rst = 1'b0; freeze = 1'b0; writeBackEn = 1'b0;
        rand_id(); id_valid = 1'b1; pc_in = 32'h200; val_rn_in = 32'hCAFE; dest_in = 4'd9;
        tick("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
